fpga_carry_chain_pipe: RTL and testbench

Parametrised, pipelined carry-chain adder/subtractor for the FPGA fabric datapath. It is the multi-bit successor to the single-cell `fpga_carry_logic`. It splits a WIDTH-bit operation into SEG_W-bit ripple segments and registers the carry and partial sum between segments, so fabric timing stays constant as WIDTH grows. A valid/ready handshake on both sides supports backpressure from downstream consumers.

---
 rtl/fpga_carry_pkg.sv | 16 +
 rtl/fpga_carry_segment.sv | 28 ++
 rtl/fpga_carry_chain_pipe.sv | 125 ++++++++++++
 tb/tb_fpga_carry_chain_pipe.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_carry_pkg.sv
// Shared types and sizing helpers for the pipelined carry-chain adder.
package fpga_carry_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned DEFAULT_SEG_W = 8;

  typedef enum logic {
    CARRY_ADD = 1'b0,
    CARRY_SUB = 1'b1
  } carry_mode_e;

  function automatic int unsigned nseg(input int unsigned width, input int unsigned seg_w);
    return width / seg_w;
  endfunction

endpackage

// File: rtl/fpga_carry_segment.sv
// Combinational SEG_W-bit ripple segment built from the per-bit carry cell.
module fpga_carry_segment #(
  parameter int unsigned SEG_W = 8
) (
  input  logic [SEG_W-1:0] a_i,
  input  logic [SEG_W-1:0] b_i,
  input  logic             ci_i,
  output logic [SEG_W-1:0] s_o,
  output logic             co_o,
  output logic             c_msb_in_o
);

  logic [SEG_W:0] c;

  always_comb begin
    c    = '0;
    s_o  = '0;
    c[0] = ci_i;
    for (int unsigned i = 0; i < SEG_W; i++) begin
      s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign co_o       = c[SEG_W];
  assign c_msb_in_o = c[SEG_W-1];

endmodule

// File: rtl/fpga_carry_chain_pipe.sv
// Pipelined carry-chain adder/subtractor: one SEG_W-bit ripple per stage,
// global-advance valid/ready flow control, bubbles travel with the data.
module fpga_carry_chain_pipe
  import fpga_carry_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned SEG_W = DEFAULT_SEG_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             carry_in_i,
  input  logic             sub_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_out_o,
  output logic             overflow_o
);

  localparam int unsigned NSEG = nseg(WIDTH, SEG_W);

  if ((WIDTH % SEG_W) != 0) begin : g_bad_param
    $error("fpga_carry_chain_pipe: WIDTH must be a multiple of SEG_W");
  end

  // Stage k holds operands, the carry into segment k and sum segments 0..k-1.
  logic [NSEG-1:0]  vld_q, vld_d;
  logic [WIDTH-1:0] a_q    [NSEG];
  logic [WIDTH-1:0] a_d    [NSEG];
  logic [WIDTH-1:0] b_q    [NSEG];
  logic [WIDTH-1:0] b_d    [NSEG];
  logic [WIDTH-1:0] s_q    [NSEG];
  logic [WIDTH-1:0] s_d    [NSEG];
  logic             c_q    [NSEG];
  logic             c_d    [NSEG];
  carry_mode_e      mode_q [NSEG];
  carry_mode_e      mode_d [NSEG];

  logic [SEG_W-1:0] seg_s  [NSEG];
  logic             seg_co [NSEG];
  logic             seg_cm [NSEG];
  logic             advance;

  for (genvar g = 0; g < NSEG; g++) begin : g_seg
    logic [SEG_W-1:0] b_eff;
    assign b_eff = b_q[g][g*SEG_W +: SEG_W] ^ {SEG_W{mode_q[g] == CARRY_SUB}};

    fpga_carry_segment #(.SEG_W(SEG_W)) u_seg (
      .a_i        (a_q[g][g*SEG_W +: SEG_W]),
      .b_i        (b_eff),
      .ci_i       (c_q[g]),
      .s_o        (seg_s[g]),
      .co_o       (seg_co[g]),
      .c_msb_in_o (seg_cm[g])
    );
  end

  assign advance    = ~vld_q[NSEG-1] | out_ready_i;
  assign in_ready_o = advance;

  always_comb begin
    vld_d = vld_q;
    for (int unsigned k = 0; k < NSEG; k++) begin
      a_d[k]    = a_q[k];
      b_d[k]    = b_q[k];
      s_d[k]    = s_q[k];
      c_d[k]    = c_q[k];
      mode_d[k] = mode_q[k];
    end
    if (advance) begin
      vld_d[0]  = in_valid_i;
      a_d[0]    = a_i;
      b_d[0]    = b_i;
      s_d[0]    = '0;
      c_d[0]    = carry_in_i ^ sub_i;
      mode_d[0] = sub_i ? CARRY_SUB : CARRY_ADD;
      for (int unsigned k = 1; k < NSEG; k++) begin
        vld_d[k]  = vld_q[k-1];
        a_d[k]    = a_q[k-1];
        b_d[k]    = b_q[k-1];
        mode_d[k] = mode_q[k-1];
        c_d[k]    = seg_co[k-1];
        s_d[k]    = s_q[k-1];
        s_d[k][(k-1)*SEG_W +: SEG_W] = seg_s[k-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vld_q <= '0;
      for (int unsigned k = 0; k < NSEG; k++) begin
        a_q[k]    <= '0;
        b_q[k]    <= '0;
        s_q[k]    <= '0;
        c_q[k]    <= 1'b0;
        mode_q[k] <= CARRY_ADD;
      end
    end else begin
      vld_q <= vld_d;
      for (int unsigned k = 0; k < NSEG; k++) begin
        a_q[k]    <= a_d[k];
        b_q[k]    <= b_d[k];
        s_q[k]    <= s_d[k];
        c_q[k]    <= c_d[k];
        mode_q[k] <= mode_d[k];
      end
    end
  end

  // The top segment resolves combinationally from the last stage register.
  always_comb begin
    sum_o = s_q[NSEG-1];
    sum_o[(NSEG-1)*SEG_W +: SEG_W] = seg_s[NSEG-1];
  end

  assign out_valid_o = vld_q[NSEG-1];
  assign carry_out_o = seg_co[NSEG-1];
  assign overflow_o  = seg_co[NSEG-1] ^ seg_cm[NSEG-1];

endmodule

// File: tb/tb_fpga_carry_chain_pipe.sv
// Bench for fpga_carry_chain_pipe: directed cases on a 32/8 instance plus a
// randomised parameter sweep checked against an arithmetic reference model.
module tb_fpga_carry_chain_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, sum;
  logic        ci, sub, co, ov;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fpga_carry_chain_pipe #(.WIDTH(32), .SEG_W(8)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .a_i(a), .b_i(b), .carry_in_i(ci), .sub_i(sub),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .sum_o(sum), .carry_out_o(co), .overflow_o(ov)
  );

  function automatic int cfg_w(input int g);
    case (g)
      0: return 8;
      1: return 8;
      2: return 32;
      default: return 64;
    endcase
  endfunction

  function automatic int cfg_s(input int g);
    case (g)
      0: return 1;
      1: return 8;
      2: return 4;
      default: return 16;
    endcase
  endfunction

  logic        sw_valid, sw_ready, sw_ci, sw_sub;
  logic [63:0] sw_a, sw_b;
  logic [3:0]  sw_in_ready, sw_out_valid, sw_co, sw_ov;
  logic [63:0] sw_sum [4];

  for (genvar g = 0; g < 4; g++) begin : g_sw
    localparam int W = cfg_w(g);
    localparam int S = cfg_s(g);
    logic [W-1:0] s;
    fpga_carry_chain_pipe #(.WIDTH(W), .SEG_W(S)) u_dut (
      .clk_i(clk), .rst_ni(rst_n),
      .in_valid_i(sw_valid), .in_ready_o(sw_in_ready[g]),
      .a_i(sw_a[W-1:0]), .b_i(sw_b[W-1:0]), .carry_in_i(sw_ci), .sub_i(sw_sub),
      .out_valid_o(sw_out_valid[g]), .out_ready_i(sw_ready),
      .sum_o(s), .carry_out_o(sw_co[g]), .overflow_o(sw_ov[g])
    );
    assign sw_sum[g] = 64'(s);
  end

  typedef struct {
    logic [63:0] s;
    logic        co;
    logic        ov;
    int          t;
  } exp_t;

  exp_t sq [4][$];

  // Reference: unsigned result/carry from plain arithmetic, overflow from the
  // signed range of the mathematically exact result.
  function automatic exp_t model(input int w, input logic [63:0] a_in, input logic [63:0] b_in,
                                 input logic c_in, input logic sub_in);
    exp_t               e;
    logic [63:0]        mask, aa, bb;
    logic [64:0]        t;
    logic signed [67:0] sa, sb, r, lim;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    aa   = a_in & mask;
    bb   = b_in & mask;
    if (!sub_in) begin
      t    = {1'b0, aa} + {1'b0, bb} + 65'(c_in);
      e.s  = t[63:0] & mask;
      e.co = t[w];
    end else begin
      e.s  = (aa - bb - 64'(c_in)) & mask;
      e.co = ({1'b0, aa} >= ({1'b0, bb} + 65'(c_in)));
    end
    sa = $signed({4'b0, aa});
    sb = $signed({4'b0, bb});
    if (aa[w-1]) sa = sa - (68'sd1 <<< w);
    if (bb[w-1]) sb = sb - (68'sd1 <<< w);
    r    = sub_in ? (sa - sb - 68'(c_in)) : (sa + sb + 68'(c_in));
    lim  = 68'sd1 <<< (w - 1);
    e.ov = (r >= lim) || (r < -lim);
    e.t  = 0;
    return e;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    n_vec++; if (sum !== 32'h0) begin n_err++; $display("FAIL reset_sum got=%h exp=0", sum); end
    n_vec++; if (co !== 1'b0) begin n_err++; $display("FAIL reset_co got=%b exp=0", co); end
    n_vec++; if (ov !== 1'b0) begin n_err++; $display("FAIL reset_ov got=%b exp=0", ov); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [31:0] va  [5] = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'h12345678, 32'd5, 32'h80000000};
    logic [31:0] vb  [5] = '{32'h1, 32'h1, 32'h0, 32'd7, 32'h1};
    logic        vc  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        vs  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] es  [5] = '{32'h0, 32'h80000000, 32'h12345679, 32'hFFFFFFFE, 32'h7FFFFFFF};
    logic        eco [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        eov [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      int lat;
      @(negedge clk);
      in_valid = 1'b1; a = va[i]; b = vb[i]; ci = vc[i]; sub = vs[i]; out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      lat = 0;
      while (!out_valid && lat < 10) begin
        @(negedge clk); #1;
        lat++;
      end
      n_vec++; if (lat !== 3) begin n_err++; $display("FAIL dir%0d_latency got=%0d exp=3 edges after accept", i, lat); end
      n_vec++; if (sum !== es[i]) begin n_err++; $display("FAIL dir%0d_sum got=%h exp=%h", i, sum, es[i]); end
      n_vec++; if (co !== eco[i]) begin n_err++; $display("FAIL dir%0d_co got=%b exp=%b", i, co, eco[i]); end
      n_vec++; if (ov !== eov[i]) begin n_err++; $display("FAIL dir%0d_ov got=%b exp=%b", i, ov, eov[i]); end
    end
  endtask

  task automatic test_backpressure();
    int nxt = 0;
    int got = 0;
    for (int t = 0; t < 20; t++) begin
      logic exp_rdy;
      @(negedge clk);
      in_valid  = (nxt < 8);
      a         = 32'(nxt);
      b         = 32'(nxt);
      ci        = 1'b0;
      sub       = 1'b0;
      out_ready = !(t >= 6 && t <= 8);
      exp_rdy   = !(t >= 6 && t <= 8);
      #1;
      n_vec++; if (in_ready !== exp_rdy) begin n_err++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=%b", t, in_ready, exp_rdy); end
      if (t >= 6 && t <= 8) begin
        n_vec++;
        if (out_valid !== 1'b1 || sum !== 32'd4 || co !== 1'b0 || ov !== 1'b0) begin
          n_err++;
          $display("FAIL bp_stall cyc=%0d got v=%b sum=%h co=%b ov=%b exp v=1 sum=4 co=0 ov=0", t, out_valid, sum, co, ov);
        end
      end
      if (out_valid && out_ready) begin
        n_vec++;
        if (got >= 8) begin
          n_err++; $display("FAIL bp_extra cyc=%0d got sum=%h exp no output", t, sum);
        end else if (sum !== 32'(2 * got)) begin
          n_err++; $display("FAIL bp_order idx=%0d got=%h exp=%h", got, sum, 32'(2 * got));
        end
        got++;
      end
      if (in_valid && in_ready) nxt++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_vec++; if (got !== 8) begin n_err++; $display("FAIL bp_count got=%0d exp=8", got); end
  endtask

  task automatic test_reset_midstream();
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 32'(100 + t); b = 32'(t); ci = 1'b0; sub = 1'b0; out_ready = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_reset_valid got=%b exp=0", out_valid); end
    n_vec++; if (sum !== 32'h0) begin n_err++; $display("FAIL mid_reset_sum got=%h exp=0", sum); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mid_reset_in_ready got=%b exp=1", in_ready); end
    for (int t = 0; t < 12; t++) begin
      @(negedge clk); #1;
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_reset_stale cyc=%0d got valid=%b sum=%h exp valid=0", t, out_valid, sum); end
    end
  endtask

  task automatic test_sweep();
    localparam int NRUN = 18000;
    for (int n = 0; n < NRUN + 40; n++) begin
      @(negedge clk);
      if (n < NRUN) begin
        sw_valid = ($urandom_range(0, 3) != 0);
        sw_a     = {$urandom, $urandom};
        sw_b     = {$urandom, $urandom};
        sw_ci    = 1'($urandom_range(0, 1));
        sw_sub   = 1'($urandom_range(0, 1));
      end else begin
        sw_valid = 1'b0;
      end
      sw_ready = (n < 2000 || n >= NRUN) ? 1'b1 : ($urandom_range(0, 3) != 0);
      #1;
      for (int g = 0; g < 4; g++) begin
        if (sw_out_valid[g] && sw_ready) begin
          n_vec++;
          if (sq[g].size() == 0) begin
            n_err++; $display("FAIL sweep%0d_extra cyc=%0d got sum=%h exp no output", g, n, sw_sum[g]);
          end else begin
            exp_t e;
            e = sq[g].pop_front();
            if ({sw_sum[g], sw_co[g], sw_ov[g]} !== {e.s, e.co, e.ov}) begin
              n_err++;
              $display("FAIL sweep%0d_data cyc=%0d got sum=%h co=%b ov=%b exp sum=%h co=%b ov=%b",
                       g, n, sw_sum[g], sw_co[g], sw_ov[g], e.s, e.co, e.ov);
            end
            if (n < 2000) begin
              n_vec++;
              if (n - e.t !== cfg_w(g) / cfg_s(g)) begin
                n_err++; $display("FAIL sweep%0d_latency got=%0d exp=%0d cycles", g, n - e.t, cfg_w(g) / cfg_s(g));
              end
            end
          end
        end
        if (sw_valid && sw_in_ready[g]) begin
          exp_t e;
          e   = model(cfg_w(g), sw_a, sw_b, sw_ci, sw_sub);
          e.t = n;
          sq[g].push_back(e);
        end
      end
    end
    for (int g = 0; g < 4; g++) begin
      n_vec++;
      if (sq[g].size() != 0) begin n_err++; $display("FAIL sweep%0d_drain got=%0d pending exp=0", g, sq[g].size()); end
    end
  endtask

  initial begin
    in_valid  = 1'b0; out_ready = 1'b1; a = '0; b = '0; ci = 1'b0; sub = 1'b0;
    sw_valid  = 1'b0; sw_ready = 1'b1; sw_a = '0; sw_b = '0; sw_ci = 1'b0; sw_sub = 1'b0;
    rst_n     = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midstream();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
